// File: rtl/rf_pkg.sv
// rf_pkg: shared definitions for the register-file write-back slice.
//   REG_ADDR_W / NUM_REGS / DATA_W : register file geometry (32 x 32)
//   wb_req_t                       : one pending write {rd, data}
package rf_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;
  localparam int DATA_W     = 32;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_req_t;

endpackage

// File: rtl/rf_writeback_if.sv
// rf_writeback_if: bundles every non-clock signal of rf_writeback.
//   ALU result   : alu_valid, alu_rd, alu_data
//   load return  : ld_valid, ld_ready, ld_rd, ld_data
//   scoreboard   : pend_set, pend_rd, src0, src1, hazard0, hazard1
//   RF write port: wEn, wReg, wData
//   status       : err
// The master modport is the surrounding pipeline; slave is rf_writeback.
interface rf_writeback_if;
  import rf_pkg::*;

  logic                  alu_valid;
  logic [REG_ADDR_W-1:0] alu_rd;
  logic [DATA_W-1:0]     alu_data;
  logic                  ld_valid;
  logic                  ld_ready;
  logic [REG_ADDR_W-1:0] ld_rd;
  logic [DATA_W-1:0]     ld_data;
  logic                  pend_set;
  logic [REG_ADDR_W-1:0] pend_rd;
  logic [REG_ADDR_W-1:0] src0;
  logic [REG_ADDR_W-1:0] src1;
  logic                  hazard0;
  logic                  hazard1;
  logic                  wEn;
  logic [REG_ADDR_W-1:0] wReg;
  logic [DATA_W-1:0]     wData;
  logic                  err;

  modport master (
    output alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
           pend_set, pend_rd, src0, src1,
    input  ld_ready, hazard0, hazard1, wEn, wReg, wData, err
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
           pend_set, pend_rd, src0, src1,
    output ld_ready, hazard0, hazard1, wEn, wReg, wData, err
  );

endinterface

// File: rtl/wb_fifo.sv
// wb_fifo: DEPTH-entry synchronous FIFO of wb_req_t.
//   clk, rst_n : clock, async active-low reset (empties the FIFO)
//   push/push_data : enqueue (ignored when full)
//   pop        : dequeue head (ignored when empty)
//   head       : current head entry, valid when !empty
//   full/empty : occupancy flags
module wb_fifo
  import rf_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    push,
  input  wb_req_t push_data,
  input  logic    pop,
  output wb_req_t head,
  output logic    full,
  output logic    empty
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  wb_req_t       mem [DEPTH];
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: stale entries are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/rf_writeback.sv
// rf_writeback: merges ALU results and buffered load responses into the
// single register-file write port and tracks outstanding loads.
//   clk, rst_n : clock, async active-low reset
//   bus        : rf_writeback_if.slave (ALU, load, scoreboard, RF write, err)
// ALU results always win the write port; loads wait in wb_fifo.
module rf_writeback
  import rf_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  rf_writeback_if.slave  bus
);

  wb_req_t             alu_req;
  wb_req_t             ld_req;
  wb_req_t             head;
  wb_req_t             sel_req;
  logic                sel_valid;
  logic                fifo_full;
  logic                fifo_empty;
  logic                push;
  logic                pop;
  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_next;
  logic                err_next;

  assign alu_req = '{rd: bus.alu_rd, data: bus.alu_data};
  assign ld_req  = '{rd: bus.ld_rd,  data: bus.ld_data};

  assign bus.ld_ready = !fifo_full;
  assign push         = bus.ld_valid && !fifo_full;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (ld_req),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign bus.hazard0 = busy[bus.src0] && (bus.src0 != '0);
  assign bus.hazard1 = busy[bus.src1] && (bus.src1 != '0);

  // Priority mux, scoreboard update and error detection. The pending set is
  // applied after the pop clear so a reissued load to the same register
  // keeps it busy.
  always_comb begin
    sel_valid = 1'b0;
    sel_req   = alu_req;
    pop       = 1'b0;
    busy_next = busy;
    err_next  = bus.err;
    if (bus.alu_valid) begin
      sel_valid = 1'b1;
      sel_req   = alu_req;
    end else if (!fifo_empty) begin
      sel_valid = 1'b1;
      sel_req   = head;
      pop       = 1'b1;
    end
    if (pop) busy_next[head.rd] = 1'b0;
    if (bus.pend_set && (bus.pend_rd != '0)) busy_next[bus.pend_rd] = 1'b1;
    if (bus.alu_valid && busy[bus.alu_rd] && (bus.alu_rd != '0)) err_next = 1'b1;
    if (bus.ld_valid && fifo_full) err_next = 1'b1;
  end

  // Write-port register: address/data hold when idle; r0 writes are
  // consumed but never enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.wEn   <= 1'b0;
      bus.wReg  <= '0;
      bus.wData <= '0;
      bus.err   <= 1'b0;
      busy      <= '0;
    end else begin
      bus.wEn <= sel_valid && (sel_req.rd != '0);
      if (sel_valid) begin
        bus.wReg  <= sel_req.rd;
        bus.wData <= sel_req.data;
      end
      bus.err <= err_next;
      busy    <= busy_next;
    end
  end

endmodule
